// File: rtl/fp24_sqrt_iter.sv
// fp24_sqrt_iter: iterative fp24 square root, restoring digit recurrence,
// one result bit per cycle, valid/ready on both sides, one op in flight.
module fp24_sqrt_iter #(
  parameter int unsigned EXP_W  = 7,
  parameter int unsigned MANT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [EXP_W+MANT_W:0]   x,
  input  logic                    x_valid,
  output logic                    x_ready,
  output logic [EXP_W+MANT_W:0]   sqrt,
  output logic                    sqrt_err,
  output logic                    sqrt_valid,
  input  logic                    sqrt_ready
);

  localparam int unsigned W     = 1 + EXP_W + MANT_W;
  localparam int unsigned RAD_W = 2 * (MANT_W + 1);
  localparam int unsigned REM_W = MANT_W + 3;
  localparam int unsigned CNT_W = $clog2(MANT_W + 1);
  localparam logic [EXP_W:0] BIAS = (EXP_W+1)'((1 << (EXP_W - 1)) - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ITER,
    S_PACK,
    S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_next;

  logic [CNT_W-1:0]    r_cnt;
  logic [RAD_W-1:0]    r_rad;
  logic [REM_W-1:0]    r_rem;
  logic [MANT_W:0]     r_q;
  logic                r_sign;
  logic [EXP_W-1:0]    r_exp;
  logic [W-1:0]        r_sqrt;
  logic                r_err;

  logic                w_accept;
  logic                w_x_sign;
  logic [EXP_W-1:0]    w_x_exp;
  logic [MANT_W:0]     w_mant;
  logic [RAD_W-1:0]    w_rad_init;
  logic [REM_W+1:0]    w_rem_sh;
  logic [REM_W+1:0]    w_trial;
  logic                w_ge;
  logic [EXP_W-1:0]    w_res_exp;

  assign x_ready    = rst && (r_state == S_IDLE);
  assign sqrt_valid = (r_state == S_DONE);
  assign sqrt       = r_sqrt;
  assign sqrt_err   = r_err;

  assign w_accept = x_ready && x_valid;
  assign w_x_sign = x[W-1];
  assign w_x_exp  = x[W-2 -: EXP_W];
  assign w_mant   = {1'b1, x[MANT_W-1:0]};

  // Even exponent field means odd unbiased exponent: pre-double the mantissa
  // so the remaining exponent halves exactly.
  assign w_rad_init = w_x_exp[0] ? {1'b0, w_mant, {MANT_W{1'b0}}}
                                 : {w_mant, 1'b0, {MANT_W{1'b0}}};

  // Shifted remainder is kept two bits wider than the register so the compare
  // sees every bit; the stored remainder always fits back into REM_W.
  assign w_rem_sh  = {r_rem, r_rad[RAD_W-1 -: 2]};
  assign w_trial   = {1'b0, r_q, 2'b01};
  assign w_ge      = (w_rem_sh >= w_trial);
  assign w_res_exp = EXP_W'(({1'b0, r_exp} + BIAS) >> 1);

  // State register
  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = S_ITER;
      S_ITER: if (r_cnt == '0) w_next = S_PACK;
      S_PACK: w_next = S_DONE;
      S_DONE: if (sqrt_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Operand capture, recurrence step and result packing
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt  <= '0;
      r_rad  <= '0;
      r_rem  <= '0;
      r_q    <= '0;
      r_sign <= 1'b0;
      r_exp  <= '0;
      r_sqrt <= '0;
      r_err  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_sign <= w_x_sign;
            r_exp  <= w_x_exp;
            r_rad  <= w_rad_init;
            r_rem  <= '0;
            r_q    <= '0;
            r_cnt  <= CNT_W'(MANT_W);
          end
        end
        S_ITER: begin
          r_rad <= r_rad << 2;
          r_rem <= REM_W'(w_ge ? (w_rem_sh - w_trial) : w_rem_sh);
          r_q   <= {r_q[MANT_W-1:0], w_ge};
          r_cnt <= r_cnt - CNT_W'(1);
        end
        S_PACK: begin
          if (r_exp == '0) begin
            r_sqrt <= '0;
            r_err  <= 1'b0;
          end else if (r_sign) begin
            r_sqrt <= '0;
            r_err  <= 1'b1;
          end else begin
            r_sqrt <= {1'b0, w_res_exp, r_q[MANT_W-1:0]};
            r_err  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
